// File: rtl/byte_buf_reader.sv
// byte_buf_reader: circular byte store streamed out as a valid/ready byte
// stream. Streaming starts when a complete frame is buffered or the fill
// level reaches START_THRESH. IFG_CYCLES idle cycles follow every last byte.
// Optional BUF_RD_STATS_EN adds saturating drop and frame counters.
module byte_buf_reader #(
  parameter int DEPTH        = 8,
  parameter int IFG_CYCLES   = 12,
  parameter int START_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [7:0]               val,
  input  logic                     wr_last,
  output logic                     full,
  output logic                     ovf,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               rd_data,
  output logic                     rd_last,
  output logic                     rd_valid,
`ifdef BUF_RD_STATS_EN
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              frm_cnt,
`endif
  input  logic                     rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t          state, state_nxt;
  logic [8:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, frm, lvl;
  logic [PW-1:0]   wr_ptr_nxt, rd_ptr_nxt, frm_nxt, lvl_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [8:0]      head;
  logic            wr_acc, offer, hs, last_hs, start;

  assign lvl    = wr_ptr - rd_ptr;
  assign level  = lvl;
  assign full   = (lvl == PW'(DEPTH));
  assign empty  = (lvl == '0);
  assign wr_acc = wr & ~full;

  // Head entry falls through from storage; gated so storage is never visible
  // while nothing is offered.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign offer    = (state == STREAM) & ~empty;
  assign rd_valid = offer;
  assign rd_data  = offer ? head[7:0] : 8'h00;
  assign rd_last  = offer & head[8];
  assign hs       = offer & rd_ready;
  assign last_hs  = hs & head[8];

  // Post-edge view of pointers and frame count: lets a byte written at an
  // edge be offered in the very next cycle, and lets the gap end straight
  // into STREAM so the idle time is exactly IFG_CYCLES.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr + PW'(hs);
    frm_nxt    = frm;
    case ({wr_acc & wr_last, last_hs})
      2'b10:   frm_nxt = frm + 1'b1;
      2'b01:   frm_nxt = frm - 1'b1;
      default: frm_nxt = frm;
    endcase
    lvl_nxt = wr_ptr_nxt - rd_ptr_nxt;
    start   = (frm_nxt != '0) || (lvl_nxt >= PW'(START_THRESH));
  end

  // Storage write; not reset, contents hidden by output gating.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= {wr_last, val};
  end

  // Pointers, frame count, overflow pulse, gap counter and state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      frm     <= '0;
      ovf     <= 1'b0;
      gap_cnt <= '0;
      state   <= IDLE;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      frm     <= frm_nxt;
      ovf     <= wr & full;
      gap_cnt <= gap_nxt;
      state   <= state_nxt;
    end
  end

  // Next-state: IDLE waits for a frame or threshold, STREAM offers bytes
  // (holding through underruns), GAP counts out the inter-frame gap.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: begin
        if (last_hs) begin
          if (IFG_CYCLES == 0) begin
            state_nxt = start ? STREAM : IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GW'(IFG_CYCLES);
          end
        end
      end
      GAP: begin
        gap_nxt = gap_cnt - 1'b1;
        if (gap_cnt <= GW'(1)) state_nxt = start ? STREAM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BUF_RD_STATS_EN
  // Saturating counters of dropped writes and last-byte handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      if (wr && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      if (last_hs && frm_cnt != 16'hFFFF)    frm_cnt <= frm_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_buf_reader.sv
// Directed bench for byte_buf_reader (default parameters DEPTH=8,
// IFG_CYCLES=12, START_THRESH=4). Honors BUF_RD_STATS_EN when defined.
module tb_byte_buf_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, wr_last = 1'b0, rd_ready = 1'b0;
  logic [7:0] val = 8'h00;
  logic       full, ovf, empty, rd_last, rd_valid;
  logic [3:0] level;
  logic [7:0] rd_data;
`ifdef BUF_RD_STATS_EN
  logic [15:0] ovf_cnt, frm_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  byte_buf_reader dut (
    .clk(clk), .rst(rst), .wr(wr), .val(val), .wr_last(wr_last),
    .full(full), .ovf(ovf), .empty(empty), .level(level),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid),
`ifdef BUF_RD_STATS_EN
    .ovf_cnt(ovf_cnt), .frm_cnt(frm_cnt),
`endif
    .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; wr = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wr_byte(input logic [7:0] v, input logic l);
    wr = 1'b1; val = v; wr_last = l;
    tick();
    wr = 1'b0; wr_last = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_ovf"},   ovf, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_vld"},   rd_valid, 0);
    chk({tag, "_data"},  rd_data, 0);
    chk({tag, "_last"},  rd_last, 0);
  endtask

  initial begin
    int gap;
    int idx;
    #2;
    chk_reset_outs("rst");
    tick();
    rst = 1'b1;

    // Frame A1 A2 A3, streamed right after the A3 write, then 12 idle cycles.
    rd_ready = 1'b1;
    wr_byte(8'hA1, 0);
    chk("t1_nostart", rd_valid, 0);
    wr_byte(8'hA2, 0);
    wr_byte(8'hA3, 1);
    chk("t1_v0", rd_valid, 1); chk("t1_d0", rd_data, 8'hA1); chk("t1_l0", rd_last, 0);
    tick();
    chk("t1_v1", rd_valid, 1); chk("t1_d1", rd_data, 8'hA2); chk("t1_l1", rd_last, 0);
    tick();
    chk("t1_v2", rd_valid, 1); chk("t1_d2", rd_data, 8'hA3); chk("t1_l2", rd_last, 1);
    tick();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t1_gap%0d", i), rd_valid, 0);
      tick();
    end
    chk("t1_empty", empty, 1);

    // Fill to full, one dropped write, then ordered drain.
    do_reset();
    for (int i = 0; i < 8; i++) wr_byte(8'h10 + 8'(i), 0);
    chk("t2_full", full, 1); chk("t2_lvl8", level, 8); chk("t2_noovf", ovf, 0);
    wr_byte(8'hEE, 0);
    chk("t2_ovf", ovf, 1); chk("t2_lvl", level, 8);
    tick();
    chk("t2_ovf_pulse", ovf, 0);
`ifdef BUF_RD_STATS_EN
    chk("t2_ovf_cnt", ovf_cnt, 1);
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_v%0d", i), rd_valid, 1);
      chk($sformatf("t2_d%0d", i), rd_data, 8'h10 + i);
      tick();
    end
    chk("t2_drained", empty, 1); chk("t2_underrun", rd_valid, 0);

    // Start threshold: 2 and 3 bytes hold off, the 4th starts streaming.
    do_reset();
    rd_ready = 1'b1;
    wr_byte(8'h31, 0);
    wr_byte(8'h32, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_hold%0d", i), rd_valid, 0);
      tick();
    end
    wr_byte(8'h33, 0);
    chk("t3_hold3", rd_valid, 0); chk("t3_lvl3", level, 3);
    wr_byte(8'h34, 0);
    chk("t3_lvl4", level, 4); chk("t3_start", rd_valid, 1); chk("t3_d", rd_data, 8'h31);

    // Two buffered frames: exact 12-cycle gap between them.
    do_reset();
    wr_byte(8'hB1, 0); wr_byte(8'hB2, 1); wr_byte(8'hC1, 0); wr_byte(8'hC2, 1);
    chk("t4_lvl", level, 4);
    rd_ready = 1'b1;
    chk("t4_b1", rd_data, 8'hB1);
    tick();
    chk("t4_b2", rd_data, 8'hB2); chk("t4_b2l", rd_last, 1);
    tick();
    gap = 0;
    while (!rd_valid && gap < 40) begin
      gap++;
      tick();
    end
    chk("t4_gap", gap, 12);
    chk("t4_c1", rd_data, 8'hC1);
    tick();
    chk("t4_c2", rd_data, 8'hC2); chk("t4_c2l", rd_last, 1);
    tick();
`ifdef BUF_RD_STATS_EN
    chk("t4_frm_cnt", frm_cnt, 2);
`endif

    // Stall pattern: data held while rd_ready=0, order kept.
    do_reset();
    for (int i = 0; i < 5; i++) wr_byte(8'h51 + 8'(i), i == 4);
    idx = 0;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      rd_ready = k[0];
      chk($sformatf("t5_v%0d", k), rd_valid, 1);
      chk($sformatf("t5_d%0d", k), rd_data, 8'h51 + idx);
      chk($sformatf("t5_l%0d", k), rd_last, idx == 4);
      tick();
      if (rd_ready) idx++;
    end
    chk("t5_count", idx, 5); chk("t5_gap", rd_valid, 0);

    // Async reset mid-frame, then a single-byte frame.
    do_reset();
    for (int i = 0; i < 5; i++) wr_byte(8'h61 + 8'(i), 0);
    chk("t6_pre", rd_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
`ifdef BUF_RD_STATS_EN
    chk("t6_ovf_cnt", ovf_cnt, 0); chk("t6_frm_cnt", frm_cnt, 0);
`endif
    tick();
    rst = 1'b1;
    rd_ready = 1'b1;
    tick();
    wr_byte(8'h6A, 1);
    chk("t6_v", rd_valid, 1); chk("t6_d", rd_data, 8'h6A); chk("t6_l", rd_last, 1);
    tick();
    chk("t6_after_v", rd_valid, 0); chk("t6_after_e", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
